// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: multi-cycle LDR/STR sequencer with a request/ack
// memory handshake, a bounded wait and a one-cycle writeback select.
module mem_access_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [3:0]        Opcode,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Data,
  input  logic [DATA_W-1:0] Din,
  input  logic              MemAck,
  output logic              MemReq,
  output logic              RW,
  output logic [ADDR_W-1:0] AddressBus,
  output logic [DATA_W-1:0] Dout,
  output logic [DATA_W-1:0] LDRData,
  output logic              LDRSel,
  output logic              Busy,
  output logic              Done,
  output logic              Timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_ldr_q, is_ldr_d;
  logic [ADDR_W-1:0] abus_q, abus_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] ldr_data_q, ldr_data_d;
  logic              memreq_q, memreq_d;
  logic              rw_q, rw_d;
  logic              ldr_sel_q, ldr_sel_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  logic              op_ldr, op_str, accept;

  // Accept decode: only legal opcodes, only when the sequencer can take work
  always_comb begin
    op_ldr = (Opcode == 4'b1101);
    op_str = (Opcode == 4'b1110);
    accept = Start && (op_ldr || op_str) &&
             ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  // Next-state, datapath latches and registered-output precompute
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_ldr_d   = is_ldr_q;
    abus_d     = abus_q;
    dout_d     = dout_q;
    ldr_data_d = ldr_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d  = S_REQ;
          cnt_d    = '0;
          is_ldr_d = op_ldr;
          abus_d   = Address;
          dout_d   = op_str ? Data : '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (MemAck) begin
          state_d = S_DONE;
          if (is_ldr_q) ldr_data_d = Din;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are precomputed from the next state so they appear as flops
    memreq_d  = (state_d == S_REQ);
    rw_d      = !((state_d == S_REQ) && !is_ldr_d);
    done_d    = (state_d == S_DONE);
    ldr_sel_d = (state_d == S_DONE) && is_ldr_d;
    timeout_d = (state_d == S_ERR);
  end

  // State and output registers; async reset drops MemReq without a clock
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_ldr_q   <= 1'b1;
      abus_q     <= '0;
      dout_q     <= '0;
      ldr_data_q <= '0;
      memreq_q   <= 1'b0;
      rw_q       <= 1'b1;
      ldr_sel_q  <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_ldr_q   <= is_ldr_d;
      abus_q     <= abus_d;
      dout_q     <= dout_d;
      ldr_data_q <= ldr_data_d;
      memreq_q   <= memreq_d;
      rw_q       <= rw_d;
      ldr_sel_q  <= ldr_sel_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  // Output mapping; Busy carries the combinational accept term
  always_comb begin
    MemReq     = memreq_q;
    RW         = rw_q;
    AddressBus = abus_q;
    Dout       = dout_q;
    LDRData    = ldr_data_q;
    LDRSel     = ldr_sel_q;
    Done       = done_q;
    Timeout    = timeout_q;
    Busy       = (state_q == S_REQ) || (state_q == S_ERR) || accept;
  end

endmodule
